// File: rtl/bus_slave_mem.sv
// bus_slave_mem: memory-backed slave responder on one crossbar slave port.
//
// A request is captured in IDLE. A write is committed to the internal array
// on the capture edge. After WAIT_CYCLES wait states the block enters ACK and
// drives a single-cycle s_ack. For reads, s_rdata carries the data during
// that cycle; at all other times s_rdata is zero.
//
// Optional build macro: BUS_SLAVE_MEM_ADDR_CHECK_EN
//   defined   - nonzero s_addr[30:AW+2] marks the access out of range: the
//               write is dropped, and a read returns ERR_DATA.
//   undefined - s_addr[30:AW+2] is ignored; addresses alias modulo 2**AW words.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset
//   s_req    request, held by the master until ack
//   s_cmd    1 = write, 0 = read
//   s_addr   byte address; word index = s_addr[AW+1:2], bit 31 ignored
//   s_wdata  write data
//   s_ack    one-cycle completion pulse
//   s_rdata  read data, valid only while s_ack=1, zero otherwise
//   busy     high while a transaction waits out its wait states
module bus_slave_mem #(
    parameter int          AW          = 6,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_req,
    input  logic        s_cmd,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_wdata,
    output logic        s_ack,
    output logic [31:0] s_rdata,
    output logic        busy
);

    localparam int         DEPTH   = 2 ** AW;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    // The wait counter is 4 bits wide, so wait states are limited to 0..15.
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("bus_slave_mem: WAIT_CYCLES must be within 0..15");
    end

    logic [31:0]   mem_r [0:DEPTH-1];
    logic [1:0]    state_r;
    logic [3:0]    cnt_r;
    logic          cmd_r;
    logic [AW-1:0] idx_r;
    logic [31:0]   wdata_r;
    logic          oor_r;
    logic          s_ack_r;
    logic [31:0]   s_rdata_r;
    logic          busy_r;

    logic [AW-1:0] idx_s;
    logic          oor_s;
    logic          capture_s;
    logic          wr_en_s;
    logic [31:0]   rd_now_s;
    logic [31:0]   rd_cap_s;
    logic          addr_unused_s;

    assign idx_s     = s_addr[AW+1:2];
    assign capture_s = (state_r == ST_IDLE) && s_req;

`ifdef BUS_SLAVE_MEM_ADDR_CHECK_EN
    assign oor_s = (s_addr[30:AW+2] != '0);
`else
    assign oor_s = 1'b0;
`endif

    // Bits that never steer the datapath. The captured write data is kept
    // only for debug visibility, because the commit uses s_wdata at capture.
    assign addr_unused_s = ^{s_addr[31], s_addr[30:AW+2], wdata_r};

    // A write commits on the capture edge. No commit happens while reset is held.
    assign wr_en_s = capture_s && s_cmd && !oor_s && !reset;

    // Read data for the zero-wait case, where ACK is entered on the capture edge.
    always_comb begin
        rd_now_s = 32'h0000_0000;
        if (s_cmd) begin
            rd_now_s = 32'h0000_0000;
        end else if (oor_s) begin
            rd_now_s = ERR_DATA;
        end else begin
            rd_now_s = mem_r[idx_s];
        end
    end

    // Read data taken from the captured request, used when leaving WAIT.
    always_comb begin
        rd_cap_s = 32'h0000_0000;
        if (cmd_r) begin
            rd_cap_s = 32'h0000_0000;
        end else if (oor_r) begin
            rd_cap_s = ERR_DATA;
        end else begin
            rd_cap_s = mem_r[idx_r];
        end
    end

    // Storage array. It has no reset, so its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[idx_s] <= s_wdata;
        end
    end

    // Transaction FSM with registered ack/rdata/busy outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            cmd_r     <= 1'b0;
            idx_r     <= '0;
            wdata_r   <= 32'h0000_0000;
            oor_r     <= 1'b0;
            s_ack_r   <= 1'b0;
            s_rdata_r <= 32'h0000_0000;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    s_ack_r   <= 1'b0;
                    s_rdata_r <= 32'h0000_0000;
                    if (s_req) begin
                        cmd_r   <= s_cmd;
                        idx_r   <= idx_s;
                        wdata_r <= s_wdata;
                        oor_r   <= oor_s;
                        cnt_r   <= WAIT_LD;
                        if (WAIT_LD == 4'd0) begin
                            state_r   <= ST_ACK;
                            s_ack_r   <= 1'b1;
                            s_rdata_r <= rd_now_s;
                            busy_r    <= 1'b0;
                        end else begin
                            state_r <= ST_WAIT;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // The last wait state is spent when the counter steps from 1 to 0.
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r <= 4'd1) begin
                        state_r   <= ST_ACK;
                        s_ack_r   <= 1'b1;
                        s_rdata_r <= rd_cap_s;
                        busy_r    <= 1'b0;
                    end else begin
                        state_r <= ST_WAIT;
                        busy_r  <= 1'b1;
                    end
                end
                ST_ACK: begin
                    state_r   <= ST_IDLE;
                    s_ack_r   <= 1'b0;
                    s_rdata_r <= 32'h0000_0000;
                    busy_r    <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= 4'd0;
                    s_ack_r   <= 1'b0;
                    s_rdata_r <= 32'h0000_0000;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign s_ack   = s_ack_r;
    assign s_rdata = s_rdata_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Directed testbench for bus_slave_mem. It runs two instances: dut_a with
// WAIT_CYCLES=2 and dut_b with WAIT_CYCLES=0. The instances share clock,
// reset and the cmd/addr/wdata inputs, and each has its own request line.
module tb_bus_slave_mem;

    logic        clk;
    logic        reset;
    logic        req_a;
    logic        req_b;
    logic        cmd_s;
    logic [31:0] addr_s;
    logic [31:0] wdata_s;
    logic        ack_a;
    logic        ack_b;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        busy_a;
    logic        busy_b;

    int n_cmp;
    int n_err;
    int idle_bad;

    bus_slave_mem #(.AW(6), .WAIT_CYCLES(2), .ERR_DATA(32'hDEAD_BEEF)) dut_a (
        .clk(clk), .reset(reset), .s_req(req_a), .s_cmd(cmd_s), .s_addr(addr_s),
        .s_wdata(wdata_s), .s_ack(ack_a), .s_rdata(rdata_a), .busy(busy_a)
    );

    bus_slave_mem #(.AW(6), .WAIT_CYCLES(0), .ERR_DATA(32'hDEAD_BEEF)) dut_b (
        .clk(clk), .reset(reset), .s_req(req_b), .s_cmd(cmd_s), .s_addr(addr_s),
        .s_wdata(wdata_s), .s_ack(ack_b), .s_rdata(rdata_b), .busy(busy_b)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one transaction on dut_a (sel=0) or dut_b (sel=1). It reports the
    // sample index of the first ack, where 1 is the sample just after the
    // capture edge. It also reports the number of ack cycles, the read data
    // and busy at the first sample.
    task automatic txn(input bit sel, input logic cmd, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit drop, input bit scramble,
                       output logic [31:0] rd, output int lat, output int nack,
                       output logic busy1);
        logic        ack;
        logic [31:0] rdat;
        cmd_s   = cmd;
        addr_s  = addr;
        wdata_s = wdata;
        if (sel) req_b = 1'b1; else req_a = 1'b1;
        lat   = -1;
        nack  = 0;
        rd    = 32'h0;
        busy1 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            ack  = sel ? ack_b : ack_a;
            rdat = sel ? rdata_b : rdata_a;
            if (k == 1) begin
                busy1 = sel ? busy_b : busy_a;
                if (drop) begin
                    if (sel) req_b = 1'b0; else req_a = 1'b0;
                end
                if (scramble) begin
                    addr_s  = 32'h0000_0024;
                    wdata_s = 32'h5555_AAAA;
                end
            end
            if (ack) begin
                nack++;
                if (lat < 0) begin
                    lat = k;
                    rd  = rdat;
                    if (sel) req_b = 1'b0; else req_a = 1'b0;
                end
            end else if (rdat !== 32'h0) begin
                idle_bad++;
            end
            if (lat > 0 && k >= lat + 2) break;
        end
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    logic [31:0] rd;
    int          lat;
    int          nack;
    logic        b1;
    int          ack_cnt;
    int          bad_rst;

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        idle_bad = 0;
        reset    = 1'b1;
        req_a    = 1'b0;
        req_b    = 1'b0;
        cmd_s    = 1'b0;
        addr_s   = 32'h0;
        wdata_s  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack_a", {31'h0, ack_a}, 32'h0);
        check("rst_rdata_a", rdata_a, 32'h0);
        check("rst_busy_a", {31'h0, busy_a}, 32'h0);
        check("rst_ack_b", {31'h0, ack_b}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Write then read with two wait states.
        txn(1'b0, 1'b1, 32'h8000_0010, 32'h1234_5678, 1'b0, 1'b0, rd, lat, nack, b1);
        check("wr_lat", lat, 32'd3);
        check("wr_nack", nack, 32'd1);
        check("wr_busy", {31'h0, b1}, 32'h1);
        check("wr_rdata", rd, 32'h0);
        txn(1'b0, 1'b0, 32'h8000_0010, 32'h0, 1'b0, 1'b0, rd, lat, nack, b1);
        check("rd_lat", lat, 32'd3);
        check("rd_nack", nack, 32'd1);
        check("rd_data", rd, 32'h1234_5678);
        check("rd_busy_after", {31'h0, busy_a}, 32'h0);

        // Zero wait states: a write then a read with s_req held high throughout.
        cmd_s   = 1'b1;
        addr_s  = 32'h0000_0004;
        wdata_s = 32'hA5A5_A5A5;
        req_b   = 1'b1;
        ack_cnt = 0;
        @(posedge clk);
        #1;
        check("b2b_ack1", {31'h0, ack_b}, 32'h1);
        check("b2b_wr_rdata", rdata_b, 32'h0);
        ack_cnt += int'(ack_b);
        cmd_s = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_gap", {31'h0, ack_b}, 32'h0);
        ack_cnt += int'(ack_b);
        @(posedge clk);
        #1;
        check("b2b_ack2", {31'h0, ack_b}, 32'h1);
        check("b2b_rd_data", rdata_b, 32'hA5A5_A5A5);
        ack_cnt += int'(ack_b);
        req_b = 1'b0;
        @(posedge clk);
        #1;
        ack_cnt += int'(ack_b);
        check("b2b_ack_count", ack_cnt, 32'd2);

        // s_req dropped right after capture: the ack still pulses.
        txn(1'b0, 1'b1, 32'h0000_0008, 32'h0000_00FF, 1'b1, 1'b0, rd, lat, nack, b1);
        check("drop_nack", nack, 32'd1);
        check("drop_lat", lat, 32'd3);
        txn(1'b0, 1'b0, 32'h0000_0008, 32'h0, 1'b0, 1'b0, rd, lat, nack, b1);
        check("drop_rd", rd, 32'h0000_00FF);

        // Reset asserted during the wait states of a read.
        cmd_s  = 1'b0;
        addr_s = 32'h8000_0010;
        req_a  = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_busy", {31'h0, busy_a}, 32'h1);
        reset = 1'b1;
        req_a = 1'b0;
        #1;
        check("mid_rst_busy", {31'h0, busy_a}, 32'h0);
        bad_rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (ack_a !== 1'b0 || busy_a !== 1'b0 || rdata_a !== 32'h0) bad_rst++;
            if (i == 2) reset = 1'b0;
        end
        check("rst_quiet", bad_rst, 32'd0);
        txn(1'b0, 1'b0, 32'h8000_0010, 32'h0, 1'b0, 1'b0, rd, lat, nack, b1);
        check("post_rst_rd", rd, 32'h1234_5678);
        check("post_rst_lat", lat, 32'd3);

        // Addresses with upper bits set: checked or aliased, depending on the build.
        txn(1'b0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 1'b0, rd, lat, nack, b1);
        txn(1'b0, 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 1'b0, 1'b0, rd, lat, nack, b1);
        check("oor_wr_lat", lat, 32'd3);
        txn(1'b0, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b0, rd, lat, nack, b1);
        check("oor_rd_lat", lat, 32'd3);
`ifdef BUS_SLAVE_MEM_ADDR_CHECK_EN
        check("oor_rd", rd, 32'hDEAD_BEEF);
        txn(1'b0, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 1'b0, rd, lat, nack, b1);
        check("oor_word0", rd, 32'h0BAD_F00D);
`else
        check("alias_rd", rd, 32'hFFFF_FFFF);
        txn(1'b0, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 1'b0, rd, lat, nack, b1);
        check("alias_word0", rd, 32'hFFFF_FFFF);
`endif

        // Inputs changed during the wait states of a write to 0x20.
        txn(1'b0, 1'b1, 32'h0000_0024, 32'h2424_2424, 1'b0, 1'b0, rd, lat, nack, b1);
        txn(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_0020, 1'b0, 1'b1, rd, lat, nack, b1);
        check("scr_nack", nack, 32'd1);
        txn(1'b0, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 1'b0, rd, lat, nack, b1);
        check("scr_rd20", rd, 32'hCAFE_0020);
        txn(1'b0, 1'b0, 32'h0000_0024, 32'h0, 1'b0, 1'b0, rd, lat, nack, b1);
        check("scr_rd24", rd, 32'h2424_2424);

        check("rdata_outside_ack", idle_bad, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
